// File: rtl/i2s_rx_deserializer_if.sv
// Output bundle of the I2S receiver: a stereo pair
// offered on a valid/ready handshake.
interface i2s_rx_deserializer_if #(
  parameter int MAX_WIDTH = 32
) ();
  logic [MAX_WIDTH-1:0] out_left;
  logic [MAX_WIDTH-1:0] out_right;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output out_left,
    output out_right,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_left,
    input  out_right,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/i2s_rx_deserializer.sv
// I2S slave receiver: oversamples bclk/lrck/sdin on mclki,
// aligns to the frame and emits MSB-aligned stereo pairs.
module i2s_rx_deserializer #(
  parameter int MAX_WIDTH   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic       mclki,
  input  logic       rst,
  input  logic       enable,
  input  logic [5:0] word_width,
  input  logic       bclk,
  input  logic       lrck,
  input  logic       sdin,
  i2s_rx_deserializer_if.master out_if,
  output logic       frame_err,
  output logic       overrun
);

  localparam int IW = $clog2(MAX_WIDTH);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {
    IDLE,
    SEEK,
    LEFT,
    RIGHT
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] bclk_sr;
  logic [SYNC_STAGES-1:0] lrck_sr;
  logic [SYNC_STAGES-1:0] sdin_sr;
  logic                   bclk_prev;

  logic                 lrck_q;
  logic [CW-1:0]        bit_cnt;
  logic [CW-1:0]        w_q;
  logic [CW-1:0]        w_eff;
  logic [IW-1:0]        idx;
  logic [MAX_WIDTH-1:0] left_sr;
  logic [MAX_WIDTH-1:0] right_sr;
  logic                 pair_done;

  logic rise;
  logic lr_s;
  logic sd_s;
  logic lr_edge;

  assign rise    = bclk_sr[SYNC_STAGES-1] & ~bclk_prev;
  assign lr_s    = lrck_sr[SYNC_STAGES-1];
  assign sd_s    = sdin_sr[SYNC_STAGES-1];
  assign lr_edge = lr_s ^ lrck_q;
  assign idx     = IW'(MAX_WIDTH - 1) - bit_cnt[IW-1:0];

  always_comb begin
    w_eff = CW'(MAX_WIDTH);
    if (word_width != 6'd0 &&
        int'(word_width) <= MAX_WIDTH)
      w_eff = CW'(word_width);
  end

  always_ff @(posedge mclki) begin
    if (rst) begin
      bclk_sr   <= '0;
      lrck_sr   <= '0;
      sdin_sr   <= '0;
      bclk_prev <= 1'b0;
    end else begin
      bclk_sr   <= {bclk_sr[SYNC_STAGES-2:0], bclk};
      lrck_sr   <= {lrck_sr[SYNC_STAGES-2:0], lrck};
      sdin_sr   <= {sdin_sr[SYNC_STAGES-2:0], sdin};
      bclk_prev <= bclk_sr[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge mclki) begin
    frame_err <= 1'b0;
    overrun   <= 1'b0;
    pair_done <= 1'b0;
    if (rst || !enable) begin
      state            <= IDLE;
      lrck_q           <= 1'b0;
      bit_cnt          <= '0;
      w_q              <= '0;
      left_sr          <= '0;
      right_sr         <= '0;
      out_if.out_left  <= '0;
      out_if.out_right <= '0;
      out_if.out_valid <= 1'b0;
    end else begin
      if (rise)
        lrck_q <= lr_s;

      // A completing pair wins over acceptance only
      // when the slot is free or being freed.
      if (pair_done) begin
        if (out_if.out_valid && !out_if.out_ready) begin
          overrun <= 1'b1;
        end else begin
          out_if.out_left  <= left_sr;
          out_if.out_right <= right_sr;
          out_if.out_valid <= 1'b1;
        end
      end else if (out_if.out_valid && out_if.out_ready) begin
        out_if.out_valid <= 1'b0;
      end

      unique case (state)
        IDLE: state <= SEEK;
        SEEK: begin
          if (rise && lr_edge && !lr_s) begin
            state   <= LEFT;
            bit_cnt <= '0;
            w_q     <= w_eff;
            left_sr <= '0;
          end
        end
        LEFT: begin
          if (rise) begin
            if (lr_edge) begin
              bit_cnt <= '0;
              if (bit_cnt != w_q) begin
                frame_err <= 1'b1;
                state     <= SEEK;
              end else begin
                state    <= RIGHT;
                right_sr <= '0;
              end
            end else if (bit_cnt < w_q) begin
              left_sr[idx] <= sd_s;
              bit_cnt      <= bit_cnt + CW'(1);
            end
          end
        end
        RIGHT: begin
          if (rise) begin
            if (lr_edge) begin
              if (bit_cnt != w_q)
                frame_err <= 1'b1;
              state   <= LEFT;
              bit_cnt <= '0;
              w_q     <= w_eff;
              left_sr <= '0;
            end else if (bit_cnt < w_q) begin
              right_sr[idx] <= sd_s;
              bit_cnt       <= bit_cnt + CW'(1);
              if (bit_cnt == w_q - CW'(1))
                pair_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
